hp35_word_timer: RTL

- Word-timing and serial-bus master for the HP-35 netlist simulations; the counterpart of the ROM-side blocks that consume SYNC.
- Generates the 56-bit-time word cycle and the SYNC window.
- Serializes the ROM address onto Ia.
- Deserializes the 10-bit instruction the ROM drives on Is during SYNC.
- Replaces ad-hoc sync sources in benches and drives ROM control netlists directly.

---
 rtl/hp35_word_timer.sv | 109 ++++++++++
 1 files changed

// File: rtl/hp35_word_timer.sv
// Word timer and serial-bus master: 56-bit-time word counter, SYNC window, address out on Ia, instruction in on Is.
// Latency: sync/word_start/ia decode the registered bit_time combinationally; instr/instr_valid update on the edge leaving the last SYNC bit.
// Backpressure: none; free-running at one bit per clk, with addr_load/is_in sampled every edge.
//
// Ports:
//   clk, reset       bit-time clock; synchronous active-high reset
//   addr_in/addr_load next ROM address and its capture strobe (last load before a word boundary wins)
//   is_in            serial instruction from the ROM, LSB first, sampled while sync is high
//   bit_time         registered bit-time counter, 0..WORD_BITS-1
//   sync, word_start SYNC window and start-of-word decodes
//   ia               serial address, LSB first, inside the address window
//   instr            last complete instruction word; instr_valid pulses one cycle when it updates
module hp35_word_timer #(
    parameter int WORD_BITS  = 56,
    parameter int SYNC_START = 45,
    parameter int SYNC_LEN   = 10,
    parameter int ADDR_START = 19,
    parameter int ADDR_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic                 addr_load,
    input  logic                 is_in,
    output logic [5:0]           bit_time,
    output logic                 sync,
    output logic                 word_start,
    output logic                 ia,
    output logic [SYNC_LEN-1:0]  instr,
    output logic                 instr_valid
);

    // Window bounds are held one bit wider than bit_time so an end bound
    // equal to WORD_BITS (e.g. 56 or 64) does not wrap to zero.
    localparam logic [6:0] LAST_BT   = 7'(WORD_BITS - 1);
    localparam logic [6:0] SYNC_LO   = 7'(SYNC_START);
    localparam logic [6:0] SYNC_HI   = 7'(SYNC_START + SYNC_LEN);
    localparam logic [6:0] SYNC_LAST = 7'(SYNC_START + SYNC_LEN - 1);
    localparam logic [6:0] ADDR_LO   = 7'(ADDR_START);
    localparam logic [6:0] ADDR_HI   = 7'(ADDR_START + ADDR_BITS);

    if (WORD_BITS < 2 || WORD_BITS > 64 || SYNC_LEN < 2 || ADDR_BITS < 2 ||
        SYNC_START < 0 || ADDR_START < 0 ||
        SYNC_START + SYNC_LEN > WORD_BITS || ADDR_START + ADDR_BITS > WORD_BITS ||
        !((ADDR_START + ADDR_BITS <= SYNC_START) || (SYNC_START + SYNC_LEN <= ADDR_START)))
    begin : g_bad_params
        $error("hp35_word_timer: address and SYNC windows must fit in the word and not overlap");
    end

    logic [6:0]           bt_ext;
    logic                 in_sync_win;
    logic                 in_addr_win;
    logic                 at_wrap;
    logic                 at_sync_last;
    logic [ADDR_BITS-1:0] pending;
    logic [ADDR_BITS-1:0] addr_sr;
    logic [SYNC_LEN-1:0]  ishift;

    assign bt_ext       = {1'b0, bit_time};
    assign in_sync_win  = (bt_ext >= SYNC_LO) && (bt_ext < SYNC_HI);
    assign in_addr_win  = (bt_ext >= ADDR_LO) && (bt_ext < ADDR_HI);
    assign at_wrap      = (bt_ext == LAST_BT);
    assign at_sync_last = (bt_ext == SYNC_LAST);

    // Outputs are forced to their idle values while reset is asserted, so a
    // reset mid-word silences Ia and SYNC in the same cycle.
    assign sync       = !reset && in_sync_win;
    assign word_start = reset || (bit_time == 6'd0);
    // The address register shifts right once per window bit, so bit 0 always
    // holds the bit for the current bit time.
    assign ia         = !reset && in_addr_win && addr_sr[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_time    <= '0;
            pending     <= '0;
            addr_sr     <= '0;
            ishift      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            bit_time <= at_wrap ? 6'd0 : bit_time + 6'd1;

            if (addr_load) begin
                pending <= addr_in;
            end

            // The word in flight is frozen at the boundary; a load on the
            // boundary edge itself bypasses the pending register.
            if (at_wrap) begin
                addr_sr <= addr_load ? addr_in : pending;
            end else if (in_addr_win) begin
                addr_sr <= {1'b0, addr_sr[ADDR_BITS-1:1]};
            end

            // LSB first: after SYNC_LEN right shifts the first sampled bit sits in bit 0.
            if (in_sync_win) begin
                ishift <= {is_in, ishift[SYNC_LEN-1:1]};
            end

            instr_valid <= 1'b0;
            if (at_sync_last) begin
                instr       <= {is_in, ishift[SYNC_LEN-1:1]};
                instr_valid <= 1'b1;
            end
        end
    end

endmodule
